// File: rtl/mem_sbus_pkg.sv
// Shared types and helpers for the S-bus memory responder.
// MEM_DATA_PAR_EN widens the stored word by one bit for the data parity.
package mem_sbus_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACK_WAIT  = 2'd1,
    WORD_WAIT = 2'd2,
    WORD      = 2'd3
  } state_e;

  typedef logic [3:0]  quad_mask_t;
  typedef logic [21:0] sbus_adr_t;
  typedef logic [35:0] sbus_word_t;

  localparam int WORD_W = 36;
`ifdef MEM_DATA_PAR_EN
  localparam int STORE_W = WORD_W + 1;
`else
  localparam int STORE_W = WORD_W;
`endif

  // First set mask bit at or after 'from', walking 0..3 with wrap.
  function automatic logic [1:0] next_in_wrap(input quad_mask_t mask, input logic [1:0] from);
    logic [1:0] idx;
    next_in_wrap = from;
    for (int i = 3; i >= 0; i--) begin
      idx = from + 2'(i);
      if (mask[idx]) next_in_wrap = idx;
    end
  endfunction

endpackage

// File: rtl/mem_sbus_resp_if.sv
// MBC <-> memory S-bus signal bundle; master is the MBC side, slave the memory.
// MEM_DATA_PAR_EN adds the data parity lines and their sticky error.
interface mem_sbus_resp_if;
  import mem_sbus_pkg::*;

  logic       mem_start_h;
  quad_mask_t mem_rq_h;
  logic       mem_rd_rq_h;
  logic       mem_wr_rq_h;
  sbus_adr_t  mem_adr_h;
  logic       mem_adr_par_h;
  sbus_word_t mem_data_in_h;
  logic       mem_ackn_h;
  logic       mem_data_valid_l;
  sbus_word_t mem_data_out_h;
  logic       mem_busy_h;
  logic       adr_par_err_h;
  logic       proto_err_h;
`ifdef MEM_DATA_PAR_EN
  logic       mem_data_par_h;
  logic       mem_data_par_in_h;
  logic       data_par_err_h;

  modport master (
    output mem_start_h, mem_rq_h, mem_rd_rq_h, mem_wr_rq_h, mem_adr_h, mem_adr_par_h,
           mem_data_in_h, mem_data_par_in_h,
    input  mem_ackn_h, mem_data_valid_l, mem_data_out_h, mem_busy_h, adr_par_err_h,
           proto_err_h, mem_data_par_h, data_par_err_h
  );
  modport slave (
    input  mem_start_h, mem_rq_h, mem_rd_rq_h, mem_wr_rq_h, mem_adr_h, mem_adr_par_h,
           mem_data_in_h, mem_data_par_in_h,
    output mem_ackn_h, mem_data_valid_l, mem_data_out_h, mem_busy_h, adr_par_err_h,
           proto_err_h, mem_data_par_h, data_par_err_h
  );
`else
  modport master (
    output mem_start_h, mem_rq_h, mem_rd_rq_h, mem_wr_rq_h, mem_adr_h, mem_adr_par_h,
           mem_data_in_h,
    input  mem_ackn_h, mem_data_valid_l, mem_data_out_h, mem_busy_h, adr_par_err_h,
           proto_err_h
  );
  modport slave (
    input  mem_start_h, mem_rq_h, mem_rd_rq_h, mem_wr_rq_h, mem_adr_h, mem_adr_par_h,
           mem_data_in_h,
    output mem_ackn_h, mem_data_valid_l, mem_data_out_h, mem_busy_h, adr_par_err_h,
           proto_err_h
  );
`endif
endinterface

// File: rtl/mem_sbus_store.sv
// Core store stand-in: single address port, write on the clock edge, combinational read.
// Contents are deliberately not reset.
module mem_sbus_store #(
  parameter int ADR_BITS = 10,
  parameter int WIDTH    = 36
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADR_BITS-1:0] addr,
  input  logic [WIDTH-1:0]    wdata,
  output logic [WIDTH-1:0]    rdata
);

  logic [WIDTH-1:0] mem_q [2**ADR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_sbus_resp.sv
// S-bus memory responder: ACKN, then one DATA VALID per requested word in quad wrap order.
// MEM_DATA_PAR_EN enables stored data parity and the sticky data parity error.
module mem_sbus_resp
  import mem_sbus_pkg::*;
#(
  parameter int        ADR_BITS = 10,
  parameter sbus_adr_t BASE_ADR = 22'd0,
  parameter int        ACKN_DLY = 2,
  parameter int        ACC_DLY  = 3
) (
  input  logic           clk1_mem_h,
  input  logic           mr_reset_l,
  mem_sbus_resp_if.slave bus
);

  // Counters are preloaded and run down to zero, so WORD_WAIT holds ACC_DLY-1 cycles.
  localparam logic [3:0] ACKN_LD  = 4'(ACKN_DLY);
  localparam logic [3:0] ACC_LD   = (ACC_DLY > 1) ? 4'(ACC_DLY - 2) : 4'd0;
  localparam state_e     AFTER_ST = (ACC_DLY == 1) ? WORD : WORD_WAIT;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADR_BITS-1:0] adr_q, adr_d;
  quad_mask_t          mask_q, mask_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [1:0]          ptr_q, ptr_d;
  logic                adr_par_err_q, adr_par_err_d;
  logic                proto_err_q, proto_err_d;

  logic                ackn;
  logic                word_cyc;
  logic                we;
  quad_mask_t          mask_clr;
  sbus_adr_t           adr_off;
  logic                in_range;
  logic                par_ok;
  logic [STORE_W-1:0]  wdata;
  logic [STORE_W-1:0]  rdata;

  always_ff @(posedge clk1_mem_h or negedge mr_reset_l) begin
    if (!mr_reset_l) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      adr_q         <= '0;
      mask_q        <= '0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      ptr_q         <= '0;
      adr_par_err_q <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      adr_q         <= adr_d;
      mask_q        <= mask_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      ptr_q         <= ptr_d;
      adr_par_err_q <= adr_par_err_d;
      proto_err_q   <= proto_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    adr_d         = adr_q;
    mask_d        = mask_q;
    rd_d          = rd_q;
    wr_d          = wr_q;
    ptr_d         = ptr_q;
    adr_par_err_d = adr_par_err_q;
    proto_err_d   = proto_err_q;
    ackn          = 1'b0;
    mask_clr      = mask_q & ~(quad_mask_t'(1) << ptr_q);
    adr_off       = bus.mem_adr_h - BASE_ADR;
    in_range      = (bus.mem_adr_h >= BASE_ADR) && ((adr_off >> ADR_BITS) == '0);
    par_ok        = ^{bus.mem_adr_h, bus.mem_adr_par_h};

    if (bus.mem_start_h && (state_q != IDLE)) proto_err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.mem_start_h) begin
          adr_d  = adr_off[ADR_BITS-1:0];
          mask_d = bus.mem_rq_h;
          rd_d   = bus.mem_rd_rq_h;
          wr_d   = bus.mem_wr_rq_h;
          if (!par_ok) adr_par_err_d = 1'b1;
          if (bus.mem_rd_rq_h == bus.mem_wr_rq_h) proto_err_d = 1'b1;
          // Out-of-range addresses are dropped silently so the initiator sees NXM.
          if (par_ok && (bus.mem_rd_rq_h != bus.mem_wr_rq_h) && in_range) begin
            state_d = ACK_WAIT;
            cnt_d   = ACKN_LD;
          end
        end
      end
      ACK_WAIT: begin
        if (cnt_q == 4'd0) begin
          ackn = 1'b1;
          if (mask_q == '0) begin
            state_d = IDLE;
          end else begin
            ptr_d   = next_in_wrap(mask_q, adr_q[1:0]);
            state_d = AFTER_ST;
            cnt_d   = ACC_LD;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WORD_WAIT: begin
        if (cnt_q == 4'd0) state_d = WORD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      WORD: begin
        mask_d = mask_clr;
        if (mask_clr == '0) begin
          state_d = IDLE;
        end else begin
          ptr_d   = next_in_wrap(mask_clr, ptr_q + 2'd1);
          state_d = AFTER_ST;
          cnt_d   = ACC_LD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign word_cyc = (state_q == WORD);
  assign we       = word_cyc && wr_q;

`ifdef MEM_DATA_PAR_EN
  logic data_par_err_q, data_par_err_d;

  always_ff @(posedge clk1_mem_h or negedge mr_reset_l) begin
    if (!mr_reset_l) data_par_err_q <= 1'b0;
    else             data_par_err_q <= data_par_err_d;
  end

  // A bad-parity write is still stored; only the sticky flag records it.
  always_comb begin
    data_par_err_d = data_par_err_q;
    if (we && !(^{bus.mem_data_par_in_h, bus.mem_data_in_h})) data_par_err_d = 1'b1;
  end

  assign wdata              = {bus.mem_data_par_in_h, bus.mem_data_in_h};
  assign bus.mem_data_par_h = (word_cyc && rd_q) ? rdata[WORD_W] : 1'b0;
  assign bus.data_par_err_h = data_par_err_q;
`else
  assign wdata = bus.mem_data_in_h;
`endif

  mem_sbus_store #(
    .ADR_BITS (ADR_BITS),
    .WIDTH    (STORE_W)
  ) u_store (
    .clk   (clk1_mem_h),
    .we    (we),
    .addr  ({adr_q[ADR_BITS-1:2], ptr_q}),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign bus.mem_ackn_h       = ackn;
  assign bus.mem_data_valid_l = !word_cyc;
  assign bus.mem_data_out_h   = (word_cyc && rd_q) ? rdata[WORD_W-1:0] : '0;
  assign bus.mem_busy_h       = (state_q != IDLE);
  assign bus.adr_par_err_h    = adr_par_err_q;
  assign bus.proto_err_h      = proto_err_q;

endmodule

// File: tb/tb_mem_sbus_resp.sv
// Scoreboard bench for mem_sbus_resp: expected words are queued as stimulus is issued
// and compared against DATA VALID beats collected from the bus.
module tb_mem_sbus_resp;
  import mem_sbus_pkg::*;

  localparam int        ADR_BITS = 10;
  localparam sbus_adr_t BASE     = 22'h001000;
  localparam int        ACKN_DLY = 2;
  localparam int        ACC_DLY  = 3;
  localparam int        ACK_AT   = ACKN_DLY + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_sbus_resp_if bus ();

  mem_sbus_resp #(
    .ADR_BITS (ADR_BITS),
    .BASE_ADR (BASE),
    .ACKN_DLY (ACKN_DLY),
    .ACC_DLY  (ACC_DLY)
  ) dut (
    .clk1_mem_h (clk),
    .mr_reset_l (rst_n),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;

  sbus_word_t exp_q[$];
  sbus_word_t obs_q[$];
  sbus_word_t wdata_q[$];
  int         dv_k[$];
  int         ack_k;
  int         ack_count;
  int         busy_seen;
  int         last_busy_k;

  sbus_word_t quad_v [4] = '{36'o111111111111, 36'o222222222222, 36'o333333333333, 36'o444444444444};
  localparam sbus_word_t W5 = 36'o123456701234;

  // Issues one start and collects ACKN/DATA VALID/busy observations until the cycle ends.
  task automatic do_xfer(input sbus_adr_t adr, input quad_mask_t rq, input logic rd,
                         input logic wr, input logic par_bad, input int inject_k,
                         input int stop_dv);
    bit done = 0;
    obs_q.delete(); dv_k.delete();
    ack_k = -1; ack_count = 0; busy_seen = 0; last_busy_k = 0;
    @(negedge clk);
    bus.mem_start_h   = 1'b1;
    bus.mem_adr_h     = adr;
    bus.mem_rq_h      = rq;
    bus.mem_rd_rq_h   = rd;
    bus.mem_wr_rq_h   = wr;
    bus.mem_adr_par_h = par_bad ? ^adr : ~^adr;
    for (int k = 1; k <= 80 && !done; k++) begin
      @(negedge clk);
      if (bus.mem_ackn_h) begin ack_count++; ack_k = k; end
      if (bus.mem_busy_h) begin busy_seen = 1; last_busy_k = k; end
      if (!bus.mem_data_valid_l) begin
        dv_k.push_back(k);
        if (rd) obs_q.push_back(bus.mem_data_out_h);
        if (wr) bus.mem_data_in_h = (wdata_q.size() > 0) ? wdata_q.pop_front() : '0;
      end
      bus.mem_start_h = (k == inject_k);
      if (k == inject_k) begin
        bus.mem_adr_h     = adr ^ 22'h1;
        bus.mem_rq_h      = 4'hF;
        bus.mem_adr_par_h = ~^(adr ^ 22'h1);
      end
      if (stop_dv > 0 && dv_k.size() == stop_dv) done = 1;
      else if (k >= 8 && !bus.mem_busy_h && k > inject_k) done = 1;
    end
    bus.mem_start_h = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL xfer_timeout adr=%h busy=%0b required busy=0 within 80 cycles", adr, bus.mem_busy_h);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.mem_start_h = 1'b0; bus.mem_rq_h = '0; bus.mem_rd_rq_h = 1'b0; bus.mem_wr_rq_h = 1'b0;
    bus.mem_adr_h = '0; bus.mem_adr_par_h = 1'b1; bus.mem_data_in_h = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_ackn_h !== 1'b0) begin errors++; $display("FAIL reset_ackn got %b want 0", bus.mem_ackn_h); end
    checks++; if (bus.mem_data_valid_l !== 1'b1) begin errors++; $display("FAIL reset_dv_l got %b want 1", bus.mem_data_valid_l); end
    checks++; if (bus.mem_data_out_h !== '0) begin errors++; $display("FAIL reset_data got %o want 0", bus.mem_data_out_h); end
    checks++; if (bus.mem_busy_h !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.mem_busy_h); end
    checks++; if ({bus.adr_par_err_h, bus.proto_err_h} !== 2'b00) begin errors++; $display("FAIL reset_errs got %b want 00", {bus.adr_par_err_h, bus.proto_err_h}); end
    $display("txn reset done");
  endtask

  task automatic test_single_read();
    sbus_word_t e, o;
    wdata_q.push_back(W5);
    do_xfer(BASE + 22'd5, 4'b0010, 1'b0, 1'b1, 1'b0, 0, 0);
    exp_q.push_back(W5);
    do_xfer(BASE + 22'd5, 4'b0010, 1'b1, 1'b0, 1'b0, 0, 0);
    checks++; if (ack_k !== ACK_AT || ack_count !== 1) begin errors++; $display("FAIL single_ackn got k=%0d n=%0d want k=%0d n=1", ack_k, ack_count, ACK_AT); end
    checks++; if (dv_k.size() !== 1 || dv_k[0] !== ACK_AT + ACC_DLY) begin errors++; $display("FAIL single_dv_time got n=%0d want 1 at %0d", dv_k.size(), ACK_AT + ACC_DLY); end
    checks++; if (last_busy_k !== ACK_AT + ACC_DLY) begin errors++; $display("FAIL single_busy_drop last busy %0d want %0d", last_busy_k, ACK_AT + ACC_DLY); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++; if (o !== e) begin errors++; $display("FAIL single_data got %o want %o", o, e); end
    end
    $display("txn single_read adr=%h ackn@%0d", BASE + 22'd5, ack_k);
  endtask

  task automatic test_quad_wrap();
    sbus_word_t e, o;
    for (int i = 0; i < 4; i++) wdata_q.push_back(quad_v[i]);
    do_xfer(BASE + 22'd8, 4'hF, 1'b0, 1'b1, 1'b0, 0, 0);
    foreach (quad_v[i]) exp_q.push_back(quad_v[(i + 2) % 4]);
    do_xfer(BASE + 22'd10, 4'hF, 1'b1, 1'b0, 1'b0, 0, 0);
    checks++; if (dv_k.size() !== 4) begin errors++; $display("FAIL wrap_count got %0d want 4", dv_k.size()); end
    for (int i = 0; i < dv_k.size(); i++) begin
      checks++;
      if (dv_k[i] !== ACK_AT + ACC_DLY * (i + 1)) begin errors++; $display("FAIL wrap_time beat %0d got %0d want %0d", i, dv_k[i], ACK_AT + ACC_DLY * (i + 1)); end
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++; if (o !== e) begin errors++; $display("FAIL wrap_data beat %0d got %o want %o", i, o, e); end
    end
    $display("txn quad_wrap adr=%h beats=%0d", BASE + 22'd10, dv_k.size());
  endtask

  task automatic test_sparse_write();
    sbus_word_t e, o;
    sbus_word_t b0 = 36'o707070707070, b2 = 36'o525252525252;
    for (int i = 0; i < 4; i++) wdata_q.push_back(quad_v[i] ^ 36'o1);
    do_xfer(BASE + 22'd12, 4'hF, 1'b0, 1'b1, 1'b0, 0, 0);
    wdata_q.push_back(b0); wdata_q.push_back(b2);
    do_xfer(BASE + 22'd15, 4'b0101, 1'b0, 1'b1, 1'b0, 0, 0);
    checks++; if (dv_k.size() !== 2 || wdata_q.size() !== 0) begin errors++; $display("FAIL sparse_beats got %0d want 2", dv_k.size()); end
    exp_q.push_back(b0); exp_q.push_back(quad_v[1] ^ 36'o1);
    exp_q.push_back(b2); exp_q.push_back(quad_v[3] ^ 36'o1);
    do_xfer(BASE + 22'd12, 4'hF, 1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++; if (o !== e) begin errors++; $display("FAIL sparse_readback word %0d got %o want %o", i, o, e); end
    end
    $display("txn sparse_write adr=%h", BASE + 22'd15);
  endtask

  task automatic test_bad_parity_nxm();
    do_xfer(BASE + 22'd5, 4'b0010, 1'b1, 1'b0, 1'b1, 0, 0);
    checks++; if (ack_count !== 0 || dv_k.size() !== 0 || busy_seen !== 0) begin errors++; $display("FAIL badpar_ignored got ackn=%0d dv=%0d busy=%0d want 0 0 0", ack_count, dv_k.size(), busy_seen); end
    checks++; if (bus.adr_par_err_h !== 1'b1 || bus.proto_err_h !== 1'b0) begin errors++; $display("FAIL badpar_flags got par=%b proto=%b want 1 0", bus.adr_par_err_h, bus.proto_err_h); end
    pulse_reset();
    do_xfer(BASE + 22'(2**ADR_BITS), 4'b0010, 1'b1, 1'b0, 1'b0, 0, 0);
    checks++; if (ack_count !== 0 || dv_k.size() !== 0 || busy_seen !== 0) begin errors++; $display("FAIL nxm_ignored got ackn=%0d dv=%0d busy=%0d want 0 0 0", ack_count, dv_k.size(), busy_seen); end
    checks++; if (bus.adr_par_err_h !== 1'b0) begin errors++; $display("FAIL nxm_parflag got %b want 0", bus.adr_par_err_h); end
    $display("txn bad_parity_nxm done");
  endtask

  task automatic test_proto();
    sbus_word_t o;
    do_xfer(BASE + 22'd5, 4'b0010, 1'b1, 1'b0, 1'b0, 1, 0);
    o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
    checks++; if (bus.proto_err_h !== 1'b1) begin errors++; $display("FAIL proto_busy_flag got %b want 1", bus.proto_err_h); end
    checks++; if (ack_k !== ACK_AT || dv_k.size() !== 1 || o !== W5) begin errors++; $display("FAIL proto_busy_cycle got ackn@%0d dv=%0d data=%o want %0d 1 %o", ack_k, dv_k.size(), o, ACK_AT, W5); end
    pulse_reset();
    do_xfer(BASE + 22'd5, 4'b0010, 1'b1, 1'b1, 1'b0, 0, 0);
    checks++; if (bus.proto_err_h !== 1'b1 || ack_count !== 0 || busy_seen !== 0) begin errors++; $display("FAIL proto_rdwr got proto=%b ackn=%0d busy=%0d want 1 0 0", bus.proto_err_h, ack_count, busy_seen); end
    $display("txn proto done");
  endtask

  task automatic test_reset_mid();
    sbus_word_t e, o;
    int late_dv = 0, late_busy = 0;
    do_xfer(BASE + 22'd5, 4'b0010, 1'b1, 1'b0, 1'b1, 0, 0);
    exp_q.push_back(quad_v[0]); exp_q.push_back(quad_v[1]);
    do_xfer(BASE + 22'd8, 4'hF, 1'b1, 1'b0, 1'b0, 0, 2);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++; if (o !== e) begin errors++; $display("FAIL midrst_pre word %0d got %o want %o", i, o, e); end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_busy_h !== 1'b0 || bus.mem_data_valid_l !== 1'b1 || bus.mem_ackn_h !== 1'b0 || bus.mem_data_out_h !== '0) begin errors++; $display("FAIL midrst_outputs got busy=%b dv_l=%b ackn=%b want 0 1 0", bus.mem_busy_h, bus.mem_data_valid_l, bus.mem_ackn_h); end
    checks++; if ({bus.adr_par_err_h, bus.proto_err_h} !== 2'b00) begin errors++; $display("FAIL midrst_errs got %b want 00", {bus.adr_par_err_h, bus.proto_err_h}); end
    @(negedge clk); rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!bus.mem_data_valid_l) late_dv++;
      if (bus.mem_busy_h) late_busy++;
    end
    checks++; if (late_dv !== 0 || late_busy !== 0) begin errors++; $display("FAIL midrst_quiet got dv=%0d busy=%0d want 0 0", late_dv, late_busy); end
    do_xfer(BASE + 22'd5, 4'b0010, 1'b1, 1'b0, 1'b0, 0, 0);
    o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
    checks++; if (ack_k !== ACK_AT || o !== W5) begin errors++; $display("FAIL midrst_next got ackn@%0d data=%o want %0d %o", ack_k, o, ACK_AT, W5); end
    $display("txn reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_quad_wrap();
    test_sparse_write();
    test_bad_parity_nxm();
    test_proto();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
